// File: rtl/mure_pkg.sv
// Shared types and field widths for the multiple-retirement trace path.
package mure_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INST_LEN  = 32;
    localparam int unsigned CAUSE_LEN = 5;
    localparam int unsigned PRIV_LEN  = 2;
    localparam int unsigned ITYPE_LEN = 3;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [INST_LEN-1:0]  inst_data;
        logic [ITYPE_LEN-1:0] itype;
        logic                 compressed;
        logic                 exception;
        logic                 interrupt;
        logic                 eret;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } uop_entry_s;

    // Per-lane part of a commit bundle
    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] inst_data;
        logic                compressed;
        logic                exception;
        logic                interrupt;
        logic                eret;
    } lane_s;

    // Bundle-shared part of a commit bundle
    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } shared_s;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with flush; pushes while full and pops while empty are ignored.
module fifo_v3 #(
    parameter int unsigned DEPTH = 8,
    parameter type dtype = logic,
    localparam int unsigned ADDR_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_q, wr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    dtype                  mem_q [DEPTH];
    logic                  push_eff, pop_eff;

    assign full_o   = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign usage_o  = cnt_q[ADDR_DEPTH-1:0];
    assign data_o   = mem_q[rd_q];
    assign push_eff = push_i & ~full_o;
    assign pop_eff  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_eff) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_eff) rd_q <= rd_q + 1'b1;
            case ({push_eff, pop_eff})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mure_commit_serializer.sv
// Buffers NRET-wide commit bundles and emits their retired uops one per cycle in program order.
module mure_commit_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [NRET-1:0]                 valid_i,
    input  logic [NRET-1:0][XLEN-1:0]       pc_i,
    input  logic [NRET-1:0][INST_LEN-1:0]   inst_data_i,
    input  logic [NRET-1:0]                 compressed_i,
    input  logic [NRET-1:0]                 exception_i,
    input  logic [CAUSE_LEN-1:0]            cause_i,
    input  logic [XLEN-1:0]                 tval_i,
    input  logic [PRIV_LEN-1:0]             priv_i,
    input  logic                            interrupt_i,
    input  logic                            eret_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [$bits(uop_entry_s)-1:0]   uop_o,
    output logic [$clog2(DEPTH):0]          usage_o,
    output logic                            overflow_o
);

    typedef struct packed {
        logic [NRET-1:0]   valid;
        lane_s [NRET-1:0]  lane;
        shared_s           shared;
    } bundle_s;

    bundle_s                 in_bundle, head;
    logic                    push_req, fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(DEPTH)-1:0] fifo_usage;
    logic [NRET-1:0]         done_q, pending, cur_oh;
    logic                    last_lane, handshake, overflow_q;
    uop_entry_s              uop;

    // Lanes past the first exception are squashed; interrupt/eret ride on the youngest survivor
    always_comb begin
        logic seen_exc;
        logic above;
        in_bundle = '0;
        seen_exc  = 1'b0;
        above     = 1'b0;
        for (int unsigned i = 0; i < NRET; i++) begin
            in_bundle.valid[i]             = valid_i[i] & ~seen_exc;
            seen_exc                       = seen_exc | exception_i[i];
            in_bundle.lane[i].pc           = pc_i[i];
            in_bundle.lane[i].inst_data    = inst_data_i[i];
            in_bundle.lane[i].compressed   = compressed_i[i];
            in_bundle.lane[i].exception    = exception_i[i];
        end
        for (int unsigned k = 0; k < NRET; k++) begin
            in_bundle.lane[NRET-1-k].interrupt = interrupt_i & in_bundle.valid[NRET-1-k] & ~above;
            in_bundle.lane[NRET-1-k].eret      = eret_i & in_bundle.valid[NRET-1-k] & ~above;
            above = above | in_bundle.valid[NRET-1-k];
        end
        in_bundle.shared.cause = cause_i;
        in_bundle.shared.tval  = tval_i;
        in_bundle.shared.priv  = priv_i;
    end

    assign push_req = (|in_bundle.valid) & ~flush_i;

    fifo_v3 #(
        .DEPTH (DEPTH),
        .dtype (bundle_s)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (in_bundle),
        .push_i  (push_req),
        .data_o  (head),
        .pop_i   (fifo_pop)
    );

    // Lowest pending lane of the head bundle, as a one-hot select
    always_comb begin
        logic found;
        found   = 1'b0;
        cur_oh  = '0;
        pending = head.valid & ~done_q;
        for (int unsigned i = 0; i < NRET; i++) begin
            if (pending[i] && !found) begin
                found     = 1'b1;
                cur_oh[i] = 1'b1;
            end
        end
    end

    assign last_lane = ((pending & ~cur_oh) == '0);
    assign handshake = valid_o & ready_i;
    assign fifo_pop  = handshake & last_lane & ~flush_i;

    always_comb begin
        uop = '0;
        if (!fifo_empty) begin
            uop.valid = 1'b1;
            for (int unsigned i = 0; i < NRET; i++) begin
                if (cur_oh[i]) begin
                    uop.pc         = head.lane[i].pc;
                    uop.inst_data  = head.lane[i].inst_data;
                    uop.compressed = head.lane[i].compressed;
                    uop.exception  = head.lane[i].exception;
                    uop.interrupt  = head.lane[i].interrupt;
                    uop.eret       = head.lane[i].eret;
                end
            end
            uop.cause = head.shared.cause;
            uop.tval  = head.shared.tval;
            uop.priv  = head.shared.priv;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_req && fifo_full) overflow_q <= 1'b1;
            if (flush_i) done_q <= '0;
            else if (handshake) done_q <= last_lane ? '0 : (done_q | cur_oh);
        end
    end

    assign valid_o    = ~fifo_empty;
    assign uop_o      = uop;
    assign usage_o    = {fifo_full, fifo_usage};
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mure_commit_serializer.sv
// Scoreboarded, table-driven bench for the commit serializer (NRET=2, DEPTH=8).
module tb_mure_commit_serializer;
    import mure_pkg::*;

    localparam int unsigned NRET  = 2;
    localparam int unsigned DEPTH = 8;

    logic                          clk_i = 1'b0;
    logic                          rst_ni = 1'b0;
    logic                          flush_i = 1'b0;
    logic [NRET-1:0]               valid_i = '0;
    logic [NRET-1:0][XLEN-1:0]     pc_i = '0;
    logic [NRET-1:0][INST_LEN-1:0] inst_data_i = '0;
    logic [NRET-1:0]               compressed_i = '0;
    logic [NRET-1:0]               exception_i = '0;
    logic [CAUSE_LEN-1:0]          cause_i = '0;
    logic [XLEN-1:0]               tval_i = '0;
    logic [PRIV_LEN-1:0]           priv_i = '0;
    logic                          interrupt_i = 1'b0;
    logic                          eret_i = 1'b0;
    logic                          valid_o;
    logic                          ready_i = 1'b0;
    logic [$bits(uop_entry_s)-1:0] uop_o;
    logic [$clog2(DEPTH):0]        usage_o;
    logic                          overflow_o;
    uop_entry_s                    got;

    assign got = uop_o;

    mure_commit_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .pc_i(pc_i),
        .inst_data_i(inst_data_i), .compressed_i(compressed_i), .exception_i(exception_i),
        .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .interrupt_i(interrupt_i),
        .eret_i(eret_i), .valid_o(valid_o), .ready_i(ready_i), .uop_o(uop_o),
        .usage_o(usage_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { uop_entry_s u; bit last; } exp_t;
    typedef struct {
        logic [1:0] v, e;
        logic       intr, er;
        logic [1:0] mask;
        int         att;
    } vec_t;

    exp_t q[$];
    int   mcnt = 0;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted uop must match the oldest expectation
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (q.size() == 0) begin
                check("unexpected_uop", 128'(got), 128'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("uop", 128'(got), 128'(e.u));
                if (e.last) mcnt--;
            end
        end
    end

    // Drives one bundle for one cycle; entered and left at posedge+1
    task automatic drive(input logic [1:0] v, e, input logic [31:0] p0, p1,
                         input logic intr, er, input logic [1:0] mask, input int att);
        logic [1:0] cmp;
        cmp = 2'($urandom);
        valid_i          = v;
        exception_i      = e;
        pc_i[0]          = p0;
        pc_i[1]          = p1;
        inst_data_i[0]   = $urandom;
        inst_data_i[1]   = $urandom;
        compressed_i     = cmp;
        cause_i          = 5'($urandom);
        tval_i           = $urandom;
        priv_i           = 2'($urandom);
        interrupt_i      = intr;
        eret_i           = er;
        if (mask != 2'b00 && mcnt < int'(DEPTH)) begin
            mcnt++;
            for (int l = 0; l < 2; l++) begin
                if (mask[l]) begin
                    exp_t x;
                    x.u            = '0;
                    x.u.valid      = 1'b1;
                    x.u.pc         = (l == 1) ? p1 : p0;
                    x.u.inst_data  = inst_data_i[l];
                    x.u.compressed = cmp[l];
                    x.u.exception  = e[l];
                    x.u.interrupt  = (l == att) ? intr : 1'b0;
                    x.u.eret       = (l == att) ? er : 1'b0;
                    x.u.cause      = cause_i;
                    x.u.tval       = tval_i;
                    x.u.priv       = priv_i;
                    x.last         = (l == 1) || !mask[1];
                    q.push_back(x);
                end
            end
        end
        @(posedge clk_i); #1;
        valid_i = '0; exception_i = '0; interrupt_i = 1'b0; eret_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_timeout", 128'(q.size()), 128'(0));
        @(posedge clk_i); #1;
    endtask

    initial begin
        tbl[0] = '{2'b11, 2'b00, 1'b0, 1'b1, 2'b11, 1};
        tbl[1] = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1};
        tbl[2] = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 0};
        tbl[3] = '{2'b11, 2'b01, 1'b0, 1'b1, 2'b01, 0};
        tbl[4] = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b11, 1};
        tbl[5] = '{2'b01, 2'b10, 1'b1, 1'b0, 2'b01, 0};
        tbl[6] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 0};

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_valid", 128'(valid_o), 128'(0));
        check("rst_uop", 128'(uop_o), 128'(0));
        check("rst_usage", 128'(usage_o), 128'(0));
        check("rst_overflow", 128'(overflow_o), 128'(0));
        @(posedge clk_i); #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i); #1;

        // Two-wide bundle: uops on the two cycles after capture, then idle
        drive(2'b11, 2'b00, 32'h100, 32'h104, 1'b0, 1'b0, 2'b11, 1);
        @(negedge clk_i);
        check("t1_first_valid", 128'(valid_o), 128'(1));
        check("t1_first_pc", 128'(got.pc), 128'(32'h100));
        @(negedge clk_i);
        check("t1_second_pc", 128'(got.pc), 128'(32'h104));
        @(negedge clk_i);
        check("t1_idle", 128'(valid_o), 128'(0));
        @(posedge clk_i); #1;

        // Lane 0 idle: lane 1 emitted with no bubble
        drive(2'b10, 2'b00, 32'h200, 32'h204, 1'b0, 1'b0, 2'b10, 1);
        @(negedge clk_i);
        check("t2_pc", 128'(got.pc), 128'(32'h204));
        @(negedge clk_i);
        check("t2_idle", 128'(valid_o), 128'(0));
        @(posedge clk_i); #1;

        // Exception on lane 0 squashes lane 1 and takes eret
        drive(2'b11, 2'b01, 32'h300, 32'h304, 1'b0, 1'b1, 2'b01, 0);
        @(negedge clk_i);
        check("t3_exc_eret", 128'({got.pc, got.exception, got.eret}), 128'({32'h300, 2'b11}));
        @(negedge clk_i);
        check("t3_lane1_dropped", 128'(valid_o), 128'(0));
        @(posedge clk_i); #1;

        // Table vectors back to back
        for (int i = 0; i < 7; i++)
            drive(tbl[i].v, tbl[i].e, 32'h1000 + 32'(i * 16), 32'h1004 + 32'(i * 16),
                  tbl[i].intr, tbl[i].er, tbl[i].mask, tbl[i].att);
        drain();
        @(negedge clk_i);
        check("tbl_usage_empty", 128'(usage_o), 128'(0));
        @(posedge clk_i); #1;

        // Fill to DEPTH under back-pressure, then one more bundle overflows
        ready_i = 1'b0;
        for (int k = 0; k < 8; k++)
            drive(2'b11, 2'b00, 32'h2000 + 32'(k * 8), 32'h2004 + 32'(k * 8), 1'b0, 1'b0, 2'b11, 1);
        @(negedge clk_i);
        check("t4_usage_full", 128'(usage_o), 128'(8));
        check("t4_no_overflow_yet", 128'(overflow_o), 128'(0));
        @(posedge clk_i); #1;
        drive(2'b11, 2'b00, 32'h2f00, 32'h2f04, 1'b0, 1'b0, 2'b11, 1);
        @(negedge clk_i);
        check("t4_usage_still_full", 128'(usage_o), 128'(8));
        check("t4_overflow", 128'(overflow_o), 128'(1));
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        drain();
        @(negedge clk_i);
        check("t4_usage_drained", 128'(usage_o), 128'(0));
        check("t4_overflow_sticky", 128'(overflow_o), 128'(1));
        @(posedge clk_i); #1;

        // Stall after lane 0 acceptance; lane 1 must hold
        drive(2'b11, 2'b00, 32'h500, 32'h504, 1'b0, 1'b0, 2'b11, 1);
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("t5_hold", 128'({valid_o, got.pc}), 128'({1'b1, 32'h504}));
        end
        check("t5_usage_partial", 128'(usage_o), 128'(1));
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("t5_popped", 128'({valid_o, usage_o}), 128'(0));
        check("t5_queue_empty", 128'(q.size()), 128'(0));
        @(posedge clk_i); #1;

        // Flush with a same-cycle push
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++)
            drive(2'b11, 2'b00, 32'h600 + 32'(k * 8), 32'h604 + 32'(k * 8), 1'b0, 1'b0, 2'b11, 1);
        @(negedge clk_i);
        check("t6_usage_before", 128'(usage_o), 128'(3));
        @(posedge clk_i); #1;
        flush_i   = 1'b1;
        valid_i   = 2'b11;
        pc_i[0]   = 32'h700;
        pc_i[1]   = 32'h704;
        q.delete();
        mcnt = 0;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        valid_i = '0;
        @(negedge clk_i);
        check("t6_valid", 128'(valid_o), 128'(0));
        check("t6_usage", 128'(usage_o), 128'(0));
        check("t6_overflow", 128'(overflow_o), 128'(1));
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("t6_stays_empty", 128'(valid_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
